// File: rtl/data_mem_responder.sv
// Data-side memory responder: byte-addressable data RAM, CYCLE counter, console TX FIFO
// and STATUS register, with one-cycle registered loads and a sticky error flag.
module data_mem_responder #(
   parameter int unsigned RAM_WORDS = 1024,
   parameter logic [31:0] RAM_BASE  = 32'h1001_0000,
   parameter logic [31:0] MMIO_BASE = 32'hFF00_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [31:0] data,
   input  logic        wren,
   input  logic        rden,
   input  logic [2:0]  funct3,
   output logic [31:0] q,
   output logic        err,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);

   localparam int unsigned IDX_W     = $clog2(RAM_WORDS);
   localparam logic [31:0] RAM_BYTES = RAM_WORDS * 32'd4;
   localparam logic [31:0] CYC_ADDR  = MMIO_BASE;
   localparam logic [31:0] TX_ADDR   = MMIO_BASE + 32'h0000_0004;
   localparam logic [31:0] STAT_ADDR = MMIO_BASE + 32'h0000_0008;

   function automatic logic [31:0] load_format(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
      logic [31:0] sh;
      logic [31:0] r;
      sh = word >> {lane, 3'b000};
      case (f3)
         3'b000:  r = {{24{sh[7]}}, sh[7:0]};
         3'b001:  r = {{16{sh[15]}}, sh[15:0]};
         3'b010:  r = word;
         3'b100:  r = {24'h00_0000, sh[7:0]};
         3'b101:  r = {16'h0000, sh[15:0]};
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   logic [31:0] ram_mem [0:RAM_WORDS-1];
   logic [31:0] rd_word_q;
   logic [7:0]  fifo_mem [0:3];

   logic [31:0] cycle_q, cycle_d;
   logic        err_q, err_d, ovf_q, ovf_d;
   logic        use_ram_q, use_ram_d;
   logic [31:0] ld_imm_q, ld_imm_d;
   logic [2:0]  ld_f3_q, ld_f3_d;
   logic [1:0]  ld_lane_q, ld_lane_d;
   logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0]  cnt_q, cnt_d;

   logic [31:0] ram_off_s, ram_wdata_s, status_s;
   logic [3:0]  ram_be_s;
   logic [IDX_W-1:0] ram_idx_s;
   logic ram_hit_s, cyc_hit_s, tx_hit_s, stat_hit_s, mapped_s, f3_ok_s, misalign_s;
   logic bad_s, ld_ok_s, st_ok_s, ram_we_s, ram_re_s;
   logic full_s, pop_s, push_s, push_acc_s;

   // Address decode and access legality
   always_comb begin
      ram_off_s  = address - RAM_BASE;
      ram_hit_s  = (address >= RAM_BASE) && (ram_off_s < RAM_BYTES);
      cyc_hit_s  = (address == CYC_ADDR);
      tx_hit_s   = (address == TX_ADDR);
      stat_hit_s = (address == STAT_ADDR);
      mapped_s   = ram_hit_s | cyc_hit_s | tx_hit_s | stat_hit_s;
      case (funct3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok_s = 1'b1;
         default:                                 f3_ok_s = 1'b0;
      endcase
      misalign_s = ((funct3[1:0] == 2'b01) && address[0]) ||
                   ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
      bad_s      = (wren | rden) & (!f3_ok_s | misalign_s | !mapped_s | (wren & rden));
      ld_ok_s    = rden & !bad_s;
      st_ok_s    = wren & !bad_s;
      ram_idx_s  = ram_off_s[IDX_W+1:2];
      ram_we_s   = st_ok_s & ram_hit_s & !reset;
      ram_re_s   = ld_ok_s & ram_hit_s & !reset;
   end

   // Store lane steering: narrow data is replicated and masked by byte enables
   always_comb begin
      case (funct3[1:0])
         2'b00: begin
            ram_be_s    = 4'b0001 << address[1:0];
            ram_wdata_s = {4{data[7:0]}};
         end
         2'b01: begin
            ram_be_s    = address[1] ? 4'b1100 : 4'b0011;
            ram_wdata_s = {2{data[15:0]}};
         end
         default: begin
            ram_be_s    = 4'b1111;
            ram_wdata_s = data;
         end
      endcase
   end

   // Data RAM: byte-enable write, synchronous read (no reset so it maps to block RAM)
   always_ff @(posedge clock) begin
      if (ram_we_s) begin
         for (int i = 0; i < 4; i++) begin
            if (ram_be_s[i]) ram_mem[ram_idx_s][i*8 +: 8] <= ram_wdata_s[i*8 +: 8];
         end
      end
      if (ram_re_s) rd_word_q <= ram_mem[ram_idx_s];
   end

   // FIFO occupancy, push/pop qualification and STATUS word
   always_comb begin
      full_s     = (cnt_q == 3'd4);
      pop_s      = tx_valid & tx_ready;
      push_s     = st_ok_s & tx_hit_s;
      push_acc_s = push_s & (!full_s | pop_s);
      status_s   = {25'd0, err_q, ovf_q, cnt_q, (cnt_q == 3'd0), full_s};
   end

   // Next-state for counter, flags, load-result sideband and FIFO pointers
   always_comb begin
      cycle_d   = cycle_q + 32'd1;
      err_d     = err_q;
      ovf_d     = ovf_q;
      use_ram_d = use_ram_q;
      ld_imm_d  = ld_imm_q;
      ld_f3_d   = ld_f3_q;
      ld_lane_d = ld_lane_q;
      if (bad_s) begin
         err_d = 1'b1;
         if (rden) begin
            use_ram_d = 1'b0;
            ld_imm_d  = 32'h0000_0000;
            ld_f3_d   = 3'b010;
            ld_lane_d = 2'b00;
         end else begin
            use_ram_d = use_ram_q;
         end
      end else if (ld_ok_s) begin
         use_ram_d = ram_hit_s;
         ld_f3_d   = funct3;
         ld_lane_d = address[1:0];
         if (cyc_hit_s)       ld_imm_d = cycle_q;
         else if (stat_hit_s) ld_imm_d = status_s;
         else                 ld_imm_d = 32'h0000_0000;
      end else if (st_ok_s && stat_hit_s) begin
         err_d = 1'b0;
         ovf_d = 1'b0;
      end else begin
         err_d = err_q;
      end
      if (push_s && full_s && !pop_s) ovf_d = 1'b1;
      else                            ovf_d = ovf_d;
      wr_ptr_d = wr_ptr_q + {1'b0, push_acc_s};
      rd_ptr_d = rd_ptr_q + {1'b0, pop_s};
      cnt_d    = cnt_q + {2'b00, push_acc_s} - {2'b00, pop_s};
   end

   // State registers; reset overrides any same-cycle request
   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_q   <= 32'h0000_0000;
         err_q     <= 1'b0;
         ovf_q     <= 1'b0;
         use_ram_q <= 1'b0;
         ld_imm_q  <= 32'h0000_0000;
         ld_f3_q   <= 3'b010;
         ld_lane_q <= 2'b00;
         wr_ptr_q  <= 2'b00;
         rd_ptr_q  <= 2'b00;
         cnt_q     <= 3'd0;
      end else begin
         cycle_q   <= cycle_d;
         err_q     <= err_d;
         ovf_q     <= ovf_d;
         use_ram_q <= use_ram_d;
         ld_imm_q  <= ld_imm_d;
         ld_f3_q   <= ld_f3_d;
         ld_lane_q <= ld_lane_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   // Console FIFO storage; a push into a full FIFO with a same-cycle pop reuses the head slot
   always_ff @(posedge clock) begin
      if (push_acc_s && !reset) fifo_mem[wr_ptr_q] <= data[7:0];
   end

   // Output formatting from registered load state and FIFO head
   always_comb begin
      q        = load_format(use_ram_q ? rd_word_q : ld_imm_q, ld_f3_q, ld_lane_q);
      err      = err_q;
      tx_valid = (cnt_q != 3'd0);
      tx_data  = tx_valid ? fifo_mem[rd_ptr_q] : 8'h00;
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected load results and console bytes are
// queued when stimulus is driven and compared when the DUT presents them.
module tb_data_mem_responder;

   localparam logic [31:0] RB  = 32'h1001_0000;
   localparam logic [31:0] CYC = 32'hFF00_0000;
   localparam logic [31:0] TXA = 32'hFF00_0004;
   localparam logic [31:0] STA = 32'hFF00_0008;
   localparam logic [2:0]  F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

   logic        clock, reset, wren, rden, tx_ready, err, tx_valid;
   logic [31:0] address, data, q;
   logic [2:0]  funct3;
   logic [7:0]  tx_data;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb_q[$];
   logic [7:0]  tx_q[$];
   logic [31:0] exp_w;
   logic [7:0]  exp_b;

   data_mem_responder dut (
      .clock(clock), .reset(reset), .address(address), .data(data), .wren(wren),
      .rden(rden), .funct3(funct3), .q(q), .err(err), .tx_valid(tx_valid),
      .tx_data(tx_data), .tx_ready(tx_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      address = a; data = d; funct3 = f3; wren = 1'b1;
      cyc();
      wren = 1'b0;
   endtask

   task automatic drive_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] e);
      address = a; funct3 = f3; rden = 1'b1;
      sb_q.push_back(e);
      cyc();
      rden = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) cyc();
      reset = 1'b0;
      checks++; if (q !== 32'h0000_0000) begin errors++; $display("FAIL reset_q got %h want %h", q, 32'h0); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
      drive_load(STA, F_W, 32'h0000_0002);
      exp_w = sb_q.pop_front();
      checks++; if (q !== exp_w) begin errors++; $display("FAIL reset_status got %h want %h", q, exp_w); end
   endtask

   task automatic test_load_ext();
      logic [31:0] addrs [7];
      logic [2:0]  f3s   [7];
      logic [31:0] exps  [7];
      addrs = '{RB+32'd4, RB+32'd4, RB+32'd4, RB+32'd4, RB+32'd4, RB+32'd7, RB+32'd6};
      f3s   = '{F_B, F_BU, F_H, F_HU, F_W, F_B, F_HU};
      exps  = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF,
                32'h8000_00FF, 32'hFFFF_FF80, 32'h0000_8000};
      drive_store(RB + 32'd4, 32'h8000_00FF, F_W);
      for (int i = 0; i < 7; i++) begin
         drive_load(addrs[i], f3s[i], exps[i]);
         exp_w = sb_q.pop_front();
         checks++; if (q !== exp_w) begin errors++; $display("FAIL load_ext[%0d] got %h want %h", i, q, exp_w); end
      end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL load_ext_err got %b want 0", err); end
   endtask

   task automatic test_byte_store();
      drive_store(RB + 32'd4, 32'hAABB_CCDD, F_W);
      drive_store(RB + 32'd6, 32'h0000_0012, F_B);
      drive_load(RB + 32'd4, F_W, 32'hAA12_CCDD);
      exp_w = sb_q.pop_front();
      checks++; if (q !== exp_w) begin errors++; $display("FAIL sb_merge got %h want %h", q, exp_w); end
      drive_store(RB + 32'd6, 32'h1234_BEEF, F_H);
      checks++; if (q !== exp_w) begin errors++; $display("FAIL q_hold got %h want %h", q, exp_w); end
      drive_load(RB + 32'd4, F_W, 32'hBEEF_CCDD);
      exp_w = sb_q.pop_front();
      checks++; if (q !== exp_w) begin errors++; $display("FAIL sh_merge got %h want %h", q, exp_w); end
      drive_store(RB + 32'd5, 32'hFFFF_FF77, F_B);
      drive_load(RB + 32'd4, F_W, 32'hBEEF_77DD);
      exp_w = sb_q.pop_front();
      checks++; if (q !== exp_w) begin errors++; $display("FAIL sb_lane1 got %h want %h", q, exp_w); end
   endtask

   task automatic test_misalign_err();
      logic [31:0] addrs [7];
      logic [2:0]  f3s   [7];
      addrs = '{RB+32'd2, RB+32'd4, RB+32'd1, 32'h2000_0000, RB-32'd4, RB+32'h0000_1000, CYC+32'd1};
      f3s   = '{F_W, 3'b011, F_H, F_W, F_W, F_W, F_B};
      for (int i = 0; i < 7; i++) begin
         drive_load(RB + 32'd4, F_W, 32'hBEEF_77DD);
         exp_w = sb_q.pop_front();
         checks++; if (q !== exp_w) begin errors++; $display("FAIL bad_pre[%0d] got %h want %h", i, q, exp_w); end
         drive_load(addrs[i], f3s[i], 32'h0000_0000);
         exp_w = sb_q.pop_front();
         checks++; if (q !== exp_w) begin errors++; $display("FAIL bad_q[%0d] got %h want %h", i, q, exp_w); end
         checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err[%0d] got %b want 1", i, err); end
         if (i == 0) begin
            drive_load(STA, F_W, 32'h0000_0042);
            exp_w = sb_q.pop_front();
            checks++; if (q !== exp_w) begin errors++; $display("FAIL err_status got %h want %h", q, exp_w); end
         end
         drive_store(STA, 32'h0000_0000, F_W);
         checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear[%0d] got %b want 0", i, err); end
      end
      // simultaneous store and load must not write and must zero q
      address = RB + 32'd4; data = 32'h0000_0000; funct3 = F_W; wren = 1'b1; rden = 1'b1;
      sb_q.push_back(32'h0000_0000);
      cyc();
      wren = 1'b0; rden = 1'b0;
      exp_w = sb_q.pop_front();
      checks++; if (q !== exp_w || err !== 1'b1) begin errors++; $display("FAIL wr_rd_both got q=%h err=%b want q=%h err=1", q, err, exp_w); end
      drive_store(RB + 32'd5, 32'h0000_0000, F_H);
      drive_store(STA, 32'h0000_0000, F_B);
      drive_load(RB + 32'd4, F_W, 32'hBEEF_77DD);
      exp_w = sb_q.pop_front();
      checks++; if (q !== exp_w || err !== 1'b0) begin errors++; $display("FAIL bad_store_nochange got q=%h err=%b want q=%h err=0", q, err, exp_w); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) drive_store(RB + 32'h100 + 32'(4*i), 32'h1111_1111 * 32'(i+1), F_W);
      drive_store(RB + 32'h0000_0FFC, 32'hCAFE_F00D, F_W);
      for (int i = 0; i < 4; i++) begin
         address = RB + 32'h100 + 32'(4*i); funct3 = F_W; rden = 1'b1;
         sb_q.push_back(32'h1111_1111 * 32'(i+1));
         cyc();
         exp_w = sb_q.pop_front();
         checks++; if (q !== exp_w) begin errors++; $display("FAIL b2b[%0d] got %h want %h", i, q, exp_w); end
      end
      rden = 1'b0;
      drive_load(RB + 32'h0000_0FFC, F_W, 32'hCAFE_F00D);
      exp_w = sb_q.pop_front();
      checks++; if (q !== exp_w || err !== 1'b0) begin errors++; $display("FAIL top_word got q=%h err=%b want q=%h err=0", q, err, exp_w); end
   endtask

   task automatic test_fifo_overflow();
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp_b = 8'h41 + 8'(i);
         if (tx_q.size() < 4) tx_q.push_back(exp_b);
         drive_store(TXA, {24'h00_0000, exp_b}, F_B);
      end
      drive_load(STA, F_W, 32'h0000_0031);
      exp_w = sb_q.pop_front();
      checks++; if (q !== exp_w) begin errors++; $display("FAIL ovf_status got %h want %h", q, exp_w); end
      drive_load(TXA, F_W, 32'h0000_0000);
      exp_w = sb_q.pop_front();
      checks++; if (q !== exp_w || err !== 1'b0) begin errors++; $display("FAIL txdata_load got q=%h err=%b want q=%h err=0", q, err, exp_w); end
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_b = tx_q.pop_front();
         checks++; if (tx_valid !== 1'b1 || tx_data !== exp_b) begin errors++; $display("FAIL ovf_drain[%0d] got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp_b); end
         cyc();
      end
      tx_ready = 1'b0;
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", tx_valid); end
      drive_store(STA, 32'h0000_0000, F_W);
      drive_load(STA, F_W, 32'h0000_0002);
      exp_w = sb_q.pop_front();
      checks++; if (q !== exp_w) begin errors++; $display("FAIL ovf_clear got %h want %h", q, exp_w); end
   endtask

   task automatic test_full_push_pop();
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_b = 8'h61 + 8'(i);
         tx_q.push_back(exp_b);
         drive_store(TXA, {24'h00_0000, exp_b}, F_B);
      end
      address = TXA; data = 32'h0000_0058; funct3 = F_B; wren = 1'b1; tx_ready = 1'b1;
      exp_b = tx_q.pop_front();
      tx_q.push_back(8'h58);
      checks++; if (tx_valid !== 1'b1 || tx_data !== exp_b) begin errors++; $display("FAIL fpp_head got v=%b d=%h want v=1 d=%h", tx_valid, tx_data, exp_b); end
      cyc();
      wren = 1'b0; tx_ready = 1'b0;
      drive_load(STA, F_W, 32'h0000_0011);
      exp_w = sb_q.pop_front();
      checks++; if (q !== exp_w) begin errors++; $display("FAIL fpp_status got %h want %h", q, exp_w); end
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_b = tx_q.pop_front();
         checks++; if (tx_valid !== 1'b1 || tx_data !== exp_b) begin errors++; $display("FAIL fpp_drain[%0d] got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp_b); end
         cyc();
      end
      tx_ready = 1'b0;
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty got %b want 0", tx_valid); end
   endtask

   task automatic test_cycle();
      int n;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin cyc(); n++; end
      drive_load(CYC, F_W, 32'(n));
      exp_w = sb_q.pop_front();
      checks++; if (q !== exp_w) begin errors++; $display("FAIL cycle_10 got %h want %h", q, exp_w); end
      address = CYC; funct3 = F_W; rden = 1'b1; reset = 1'b1;
      sb_q.push_back(32'h0000_0000);
      cyc();
      rden = 1'b0; reset = 1'b0;
      exp_w = sb_q.pop_front();
      checks++; if (q !== exp_w) begin errors++; $display("FAIL reset_mid_load got %h want %h", q, exp_w); end
      n = 0;
      for (int i = 0; i < 3; i++) begin cyc(); n++; end
      drive_load(CYC, F_W, 32'(n));
      exp_w = sb_q.pop_front();
      checks++; if (q !== exp_w) begin errors++; $display("FAIL cycle_restart got %h want %h", q, exp_w); end
      drive_store(CYC, 32'h1234_5678, F_W);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL cycle_store_err got %b want 0", err); end
   endtask

   initial begin
      reset = 1'b1; wren = 1'b0; rden = 1'b0; tx_ready = 1'b0;
      address = 32'h0000_0000; data = 32'h0000_0000; funct3 = F_W;
      test_reset();
      test_load_ext();
      test_byte_store();
      test_misalign_err();
      test_back_to_back();
      test_fifo_overflow();
      test_full_push_pop();
      test_cycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout reached without completing the run");
      $fatal(1, "timeout");
   end

endmodule
